// File: rtl/shot_sched.sv
// shot_sched: per-frame scheduler for up to four player shots.
//
// Each frame tick runs a fixed sequence: one cycle per slot to move that
// shot upward (or retire it at the top of the playfield), then one cycle
// to try to allocate a new shot from a latched fire request, subject to a
// cooldown counted in frames and to a free slot being available.
//
// Ports
//   clk          system clock, all logic on rising edge
//   rst          synchronous active-high reset
//   refr_tick    one-cycle pulse per frame; starts a sequence when idle
//   fire         one-cycle fire request, latched as pending
//   game_stop    level; clears shots/pending/cooldown and holds idle
//   gun_x_l      gun left column, used for new shot x
//   hit_valid    one-cycle pulse; hit_slot is cleared
//   hit_slot     slot index for hit_valid
//   shot_active  per-slot active flags
//   shot_x       slot i left column at [10i+9:10i]
//   shot_y       slot i top row at [10i+9:10i]
//   fire_ack     one-cycle pulse; shot allocated
//   fire_drop    one-cycle pulse; pending request discarded
//   busy         high while the sequence is running
//   shots_fired  count of allocated shots, wraps
//
// state | meaning
// IDLE  | waiting for refr_tick
// MOVE0 | move/retire slot 0
// MOVE1 | move/retire slot 1
// MOVE2 | move/retire slot 2
// MOVE3 | move/retire slot 3
// ALLOC | allocate or drop pending fire, step cooldown
module shot_sched #(
  parameter int GUN_X_SIZE = 50,
  parameter int GUN_Y_T    = 420,
  parameter int SHOT_W     = 4,
  parameter int SHOT_H     = 8,
  parameter int SHOT_V     = 6,
  parameter int TOP_Y      = 16,
  parameter int COOLDOWN   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        refr_tick,
  input  logic        fire,
  input  logic        game_stop,
  input  logic [9:0]  gun_x_l,
  input  logic        hit_valid,
  input  logic [1:0]  hit_slot,
  output logic [3:0]  shot_active,
  output logic [39:0] shot_x,
  output logic [39:0] shot_y,
  output logic        fire_ack,
  output logic        fire_drop,
  output logic        busy,
  output logic [7:0]  shots_fired
);

  localparam int CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [9:0] X_OFF  = 10'(GUN_X_SIZE / 2 - SHOT_W / 2);
  localparam logic [9:0] Y_INIT = 10'(GUN_Y_T - SHOT_H);
  localparam logic [9:0] Y_STEP = 10'(SHOT_V);
  localparam logic [9:0] Y_LIM  = 10'(TOP_Y + SHOT_V);

  typedef enum logic [2:0] {
    S_IDLE, S_MOVE0, S_MOVE1, S_MOVE2, S_MOVE3, S_ALLOC
  } state_t;

  state_t state, state_nxt;

  logic            pending;
  logic [CD_W-1:0] cd;
  logic [9:0]      x_r [4];
  logic [9:0]      y_r [4];

  logic       mv_en;
  logic [1:0] mv_idx;
  logic       mv_hit;
  logic [1:0] free_idx;
  logic       slot_free;
  logic       in_alloc;
  logic       do_alloc;
  logic       do_drop;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mv_en     = 1'b0;
    mv_idx    = 2'd0;
    case (state)
      S_IDLE:  if (refr_tick) state_nxt = S_MOVE0;
      S_MOVE0: begin mv_en = 1'b1; mv_idx = 2'd0; state_nxt = S_MOVE1; end
      S_MOVE1: begin mv_en = 1'b1; mv_idx = 2'd1; state_nxt = S_MOVE2; end
      S_MOVE2: begin mv_en = 1'b1; mv_idx = 2'd2; state_nxt = S_MOVE3; end
      S_MOVE3: begin mv_en = 1'b1; mv_idx = 2'd3; state_nxt = S_ALLOC; end
      S_ALLOC: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (game_stop) state_nxt = S_IDLE;
  end

  // Lowest-index free slot. A slot being hit this cycle still counts as
  // occupied, so only the registered flags are looked at.
  always_comb begin
    free_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!shot_active[i]) free_idx = 2'(i);
    end
  end

  assign slot_free = ~&shot_active;
  assign in_alloc  = (state == S_ALLOC);
  assign do_alloc  = in_alloc && pending && (cd == '0) && slot_free;
  assign do_drop   = in_alloc && pending && !do_alloc;
  assign mv_hit    = hit_valid && (hit_slot == mv_idx);

  always_ff @(posedge clk) begin
    if (rst) begin
      shot_active <= '0;
      pending     <= 1'b0;
      cd          <= '0;
      fire_ack    <= 1'b0;
      fire_drop   <= 1'b0;
      busy        <= 1'b0;
      shots_fired <= '0;
      for (int i = 0; i < 4; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else if (game_stop) begin
      shot_active <= '0;
      pending     <= 1'b0;
      cd          <= '0;
      fire_ack    <= 1'b0;
      fire_drop   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      fire_ack  <= do_alloc;
      fire_drop <= do_drop;
      busy      <= (state_nxt != S_IDLE);

      // A fire arriving during ALLOC carries over to the next frame.
      if (in_alloc)  pending <= fire;
      else if (fire) pending <= 1'b1;

      if (do_alloc)                 cd <= CD_LOAD;
      else if (in_alloc && cd != '0) cd <= cd - 1'b1;

      // A hit on the slot being moved wins: the slot is cleared, y untouched.
      if (mv_en && shot_active[mv_idx] && !mv_hit) begin
        if (y_r[mv_idx] < Y_LIM) shot_active[mv_idx] <= 1'b0;
        else                     y_r[mv_idx] <= y_r[mv_idx] - Y_STEP;
      end

      if (hit_valid) shot_active[hit_slot] <= 1'b0;

      // Allocation only targets an inactive slot, so it never collides with
      // a hit on an active one; a hit on this (inactive) slot is a no-op.
      if (do_alloc) begin
        shot_active[free_idx] <= 1'b1;
        x_r[free_idx]         <= gun_x_l + X_OFF;
        y_r[free_idx]         <= Y_INIT;
        shots_fired           <= shots_fired + 8'd1;
      end
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign shot_x[10*g +: 10] = x_r[g];
    assign shot_y[10*g +: 10] = y_r[g];
  end

endmodule

// File: tb/tb_shot_sched.sv
module tb_shot_sched;

  logic        clk = 1'b0;
  logic        rst, refr_tick, fire, game_stop, hit_valid;
  logic [1:0]  hit_slot;
  logic [9:0]  gun_x_l;
  logic [3:0]  shot_active;
  logic [39:0] shot_x, shot_y;
  logic        fire_ack, fire_drop, busy;
  logic [7:0]  shots_fired;

  always #5 clk = ~clk;

  shot_sched dut (
    .clk(clk), .rst(rst), .refr_tick(refr_tick), .fire(fire),
    .game_stop(game_stop), .gun_x_l(gun_x_l), .hit_valid(hit_valid),
    .hit_slot(hit_slot), .shot_active(shot_active), .shot_x(shot_x),
    .shot_y(shot_y), .fire_ack(fire_ack), .fire_drop(fire_drop),
    .busy(busy), .shots_fired(shots_fired)
  );

  localparam int COOL  = 8;
  localparam int X_OFF = 23;   // 50/2 - 4/2
  localparam int Y0    = 412;  // 420 - 8
  localparam int Y_LIM = 22;   // 16 + 6
  localparam int STEP  = 6;

  int errs = 0;
  int checks = 0;

  // Reference model: frame sequence tracked as a cycle offset into the frame
  // (0 = idle, 1..4 = moving slot offset-1, 5 = allocation cycle).
  logic [3:0] m_act;
  logic [9:0] m_x [4];
  logic [9:0] m_y [4];
  logic       m_pend, m_ack, m_drop;
  int         m_cd, m_ph;
  logic [7:0] m_sf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic f, input logic t,
                            input logic g, input logic h, input logic [1:0] hs);
    logic [3:0] nact;
    int k;
    bit done;
    if (r) begin
      m_act = '0; m_pend = 0; m_cd = 0; m_ph = 0; m_ack = 0; m_drop = 0; m_sf = '0;
      for (int i = 0; i < 4; i++) begin m_x[i] = '0; m_y[i] = '0; end
    end else if (g) begin
      m_act = '0; m_pend = 0; m_cd = 0; m_ph = 0; m_ack = 0; m_drop = 0;
    end else begin
      nact = m_act; m_ack = 0; m_drop = 0;
      if (m_ph >= 1 && m_ph <= 4) begin
        k = m_ph - 1;
        if (m_act[k] && !(h && int'(hs) == k)) begin
          if (int'(m_y[k]) < Y_LIM) nact[k] = 1'b0;
          else m_y[k] = 10'(int'(m_y[k]) - STEP);
        end
      end
      if (h) nact[hs] = 1'b0;
      if (m_ph == 5) begin
        done = 0;
        if (m_pend && m_cd == 0) begin
          for (int i = 0; i < 4; i++) begin
            if (!done && !m_act[i]) begin
              nact[i] = 1'b1;
              m_x[i]  = 10'(int'(gun_x_l) + X_OFF);
              m_y[i]  = 10'(Y0);
              done    = 1;
            end
          end
        end
        if (done) begin
          m_cd = COOL; m_sf = m_sf + 8'd1; m_ack = 1;
        end else begin
          if (m_pend) m_drop = 1;
          if (m_cd > 0) m_cd--;
        end
        m_pend = f;
      end else if (f) begin
        m_pend = 1;
      end
      m_act = nact;
      if (m_ph == 0)      m_ph = t ? 1 : 0;
      else if (m_ph == 5) m_ph = 0;
      else                m_ph++;
    end
  endtask

  task automatic cmp_model();
    logic [39:0] ex, ey;
    for (int i = 0; i < 4; i++) begin
      ex[10*i +: 10] = m_x[i];
      ey[10*i +: 10] = m_y[i];
    end
    chk("m_active", shot_active, m_act);
    chk("m_x", shot_x, ex);
    chk("m_y", shot_y, ey);
    chk("m_ack", fire_ack, m_ack);
    chk("m_drop", fire_drop, m_drop);
    chk("m_busy", busy, m_ph != 0);
    chk("m_fired", shots_fired, m_sf);
    chk("ack_drop_excl", fire_ack & fire_drop, 1'b0);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model,
  // then compare at the next falling edge.
  task automatic step(input logic r, input logic f, input logic t,
                      input logic g, input logic h, input logic [1:0] hs);
    rst = r; fire = f; refr_tick = t; game_stop = g; hit_valid = h; hit_slot = hs;
    model_step(r, f, t, g, h, hs);
    @(negedge clk);
    cmp_model();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 2'd0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 2'd0);
  endtask

  // Tick in cycle T; returns viewing T+6 (where ack/drop appear).
  task automatic frame(input logic f);
    step(0, f, 1, 0, 0, 2'd0);
    repeat (5) idle();
  endtask

  typedef struct {
    logic [9:0] gx;
    logic [9:0] ex;
  } xvec_t;

  xvec_t xtab [5];

  logic [9:0]  y_save;
  logic [39:0] x_save, yy_save;

  initial begin
    xtab[0] = '{gx: 10'd0,    ex: 10'd23};
    xtab[1] = '{gx: 10'd295,  ex: 10'd318};
    xtab[2] = '{gx: 10'd1000, ex: 10'd1023};
    xtab[3] = '{gx: 10'd1001, ex: 10'd0};
    xtab[4] = '{gx: 10'd1023, ex: 10'd22};

    rst = 1; fire = 0; refr_tick = 0; game_stop = 0; hit_valid = 0; hit_slot = 0;
    gun_x_l = 10'd295;
    @(negedge clk);

    // Reset values
    do_reset();
    chk("rst_active", shot_active, 4'd0);
    chk("rst_x", shot_x, 40'd0);
    chk("rst_y", shot_y, 40'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_fired", shots_fired, 8'd0);
    chk("rst_ack", fire_ack, 1'b0);

    // Basic allocation and first move
    frame(1);
    chk("alloc_ack", fire_ack, 1'b1);
    chk("alloc_x", shot_x[9:0], 10'd318);
    chk("alloc_y", shot_y[9:0], 10'd412);
    chk("alloc_fired", shots_fired, 8'd1);
    chk("alloc_busy_done", busy, 1'b0);
    frame(0);
    chk("move_y", shot_y[9:0], 10'd406);
    chk("move_ack_clear", fire_ack, 1'b0);

    // Cooldown: 8 drops, then accepted
    do_reset();
    frame(1);
    chk("cd_first_ack", fire_ack, 1'b1);
    for (int i = 0; i < 8; i++) begin
      frame(1);
      chk("cd_drop", fire_drop, 1'b1);
      chk("cd_no_ack", fire_ack, 1'b0);
    end
    frame(1);
    chk("cd_ack_after", fire_ack, 1'b1);
    chk("cd_fired", shots_fired, 8'd2);

    // Fill all four slots, then a request with no free slot is dropped
    repeat (8) frame(0);
    frame(1);
    repeat (8) frame(0);
    frame(1);
    chk("full_active", shot_active, 4'hf);
    repeat (8) frame(0);
    frame(1);
    chk("full_drop", fire_drop, 1'b1);
    chk("full_keep", shot_active, 4'hf);

    // Hit on slot 2 during its MOVE cycle: cleared, y held
    y_save = shot_y[29:20];
    step(0, 0, 1, 0, 0, 2'd0);
    idle();
    idle();
    step(0, 0, 0, 0, 1, 2'd2);
    chk("hitmove_active", shot_active[2], 1'b0);
    chk("hitmove_y", shot_y[29:20], y_save);
    idle();
    idle();
    step(0, 0, 0, 0, 1, 2'd1);
    chk("hit1_active", shot_active, 4'b1001);

    // game_stop clears shots, holds x/y, ignores ticks
    x_save = shot_x; yy_save = shot_y;
    step(0, 0, 0, 1, 0, 2'd0);
    chk("stop_active", shot_active, 4'd0);
    step(0, 1, 1, 1, 0, 2'd0);
    chk("stop_busy", busy, 1'b0);
    idle();
    chk("stop_busy2", busy, 1'b0);
    chk("stop_x_hold", shot_x, x_save);
    chk("stop_y_hold", shot_y, yy_save);
    frame(0);
    chk("stop_no_ack", fire_ack, 1'b0);
    chk("stop_no_drop", fire_drop, 1'b0);

    // Top boundary: y=22 moves to 16, then retires
    do_reset();
    frame(1);
    repeat (65) frame(0);
    chk("top_y22", shot_y[9:0], 10'd22);
    frame(0);
    chk("top_y16", shot_y[9:0], 10'd16);
    chk("top_active16", shot_active[0], 1'b1);
    frame(0);
    chk("top_cleared", shot_active[0], 1'b0);
    chk("top_y_hold", shot_y[9:0], 10'd16);

    // Reset mid-sequence (in MOVE1)
    do_reset();
    frame(1);
    repeat (8) frame(0);
    frame(1);
    repeat (8) frame(0);
    frame(1);
    chk("midrst_pre", shot_active, 4'b0111);
    step(0, 1, 1, 0, 0, 2'd0);
    idle();
    do_reset();
    chk("midrst_active", shot_active, 4'd0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_x", shot_x, 40'd0);
    chk("midrst_fired", shots_fired, 8'd0);
    repeat (6) idle();
    chk("midrst_no_ack", fire_ack, 1'b0);

    // x computation table, including 10-bit wrap
    for (int i = 0; i < 5; i++) begin
      do_reset();
      gun_x_l = xtab[i].gx;
      frame(1);
      chk("tab_ack", fire_ack, 1'b1);
      chk("tab_x", shot_x[9:0], xtab[i].ex);
    end

    // Random stimulus against the model
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      gun_x_l = 10'($urandom);
      step($urandom_range(0, 799) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 99) == 0,
           $urandom_range(0, 11) == 0,
           2'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/shot_sched.md
SHOT_SCHED -- requirements
Module: shot_sched

Interface
REQ-001 Parameter GUN_X_SIZE, default 50, gun width in pixels.
REQ-002 Parameter GUN_Y_T, default 420, gun top row.
REQ-003 Parameter SHOT_W, default 4, shot width in pixels.
REQ-004 Parameter SHOT_H, default 8, shot height in pixels.
REQ-005 Parameter SHOT_V, default 6, upward pixels per frame.
REQ-006 Parameter TOP_Y, default 16, first playfield row below the text band.
REQ-007 Parameter COOLDOWN, default 8, frames between accepted shots.
REQ-008 clk  in  1  system clock; the only clock, all logic on its rising edge.
REQ-009 rst  in  1  reset; synchronous, active-high.
REQ-010 refr_tick  in  1  one-cycle pulse, once per frame.
REQ-011 fire  in  1  one-cycle fire request pulse.
REQ-012 game_stop  in  1  level; high while the game is not in play.
REQ-013 gun_x_l  in  10  current gun left column.
REQ-014 hit_valid  in  1  one-cycle pulse; the collision logic reports a shot hit.
REQ-015 hit_slot  in  2  slot index qualified by hit_valid.
REQ-016 shot_active  out  4  per-slot active flags.
REQ-017 shot_x  out  40  slot i left column at bits [10i+9:10i].
REQ-018 shot_y  out  40  slot i top row at bits [10i+9:10i].
REQ-019 fire_ack  out  1  one-cycle pulse; shot allocated.
REQ-020 fire_drop  out  1  one-cycle pulse; pending request discarded.
REQ-021 busy  out  1  high whenever the FSM is not in IDLE.
REQ-022 shots_fired  out  8  count of allocated shots, wraps 255->0.

Function
REQ-023 The FSM SHALL have states IDLE, MOVE0, MOVE1, MOVE2, MOVE3 and ALLOC, and all outputs SHALL be registered.
REQ-024 In IDLE, refr_tick=1 in cycle T SHALL cause MOVEk to occupy cycle T+1+k, ALLOC to occupy T+5, and IDLE again from T+6.
REQ-025 refr_tick while busy=1 SHALL be ignored.
REQ-026 In MOVEk with slot k active and shot_y[k] < TOP_Y+SHOT_V, the block SHALL clear slot k.
REQ-027 In MOVEk with slot k active otherwise, the block SHALL set shot_y[k] to shot_y[k]-SHOT_V.
REQ-028 In MOVEk with slot k inactive, slot k SHALL be unchanged.
REQ-029 A pending flag SHALL be set by fire=1 in any cycle.
REQ-030 The pending flag SHALL be cleared in ALLOC, unless fire=1 in that same cycle, in which case it stays set.
REQ-031 In ALLOC with pending, cooldown counter =0 and a free slot: the lowest-index inactive slot SHALL become active.
REQ-032 On that allocation, x SHALL be gun_x_l+GUN_X_SIZE/2-SHOT_W/2 (10-bit truncation) and y SHALL be GUN_Y_T-SHOT_H.
REQ-033 On that allocation, the cooldown counter SHALL be loaded with COOLDOWN, shots_fired SHALL increment, and fire_ack SHALL pulse in T+6.
REQ-034 In ALLOC with pending but cooldown counter ≠0 or no free slot: no allocation, and fire_drop SHALL pulse in T+6.
REQ-035 In ALLOC without an allocation, a nonzero cooldown counter SHALL decrement by 1.
REQ-036 hit_valid=1 in cycle c SHALL clear shot_active[hit_slot] from c+1.
REQ-037 hit_valid on an inactive slot SHALL have no effect.
REQ-038 When hit_valid and MOVEk target the same slot in the same cycle, the clear SHALL win.
REQ-039 Allocation SHALL treat a slot being hit-cleared in the same cycle as still occupied.
REQ-040 game_stop=1 SHALL, from the next cycle, clear shot_active, pending and the cooldown counter, and force IDLE.
REQ-041 While game_stop=1, fire and refr_tick SHALL be ignored; shot_x, shot_y and shots_fired SHALL hold.
REQ-042 The block SHALL never assert fire_ack and fire_drop in the same cycle.

Reset
REQ-043 rst=1 at a clock edge SHALL force IDLE and clear pending and the cooldown counter, with precedence over all other inputs, including mid-sequence.
REQ-044 After reset, shot_active=0, shot_x=0, shot_y=0, fire_ack=0, fire_drop=0, busy=0 and shots_fired=0.

Verification
REQ-045 gun_x_l=295, fire, then refr_tick at T -> fire_ack in T+6, slot0 x=318 y=412, shots_fired=1; next frame slot0 y=406.
REQ-046 Fire accepted, then fire on each of the next 8 frames -> 8 fire_drop pulses; fire on frame 9 -> fire_ack.
REQ-047 Four slots active, cooldown 0, fire + refr_tick -> fire_drop in T+6, shot_active stays 4'b1111.
REQ-048 Slot1 active at y=20, refr_tick -> slot1 cleared; hit_valid with hit_slot=2 in the MOVE2 cycle -> slot2 cleared, y unchanged.
REQ-049 Slots 0-2 active, fire, rst in the MOVE1 cycle -> next cycle all outputs at reset values, busy=0.
REQ-050 game_stop=1 with slots 0 and 3 active -> shot_active=0 next cycle; refr_tick while stopped -> busy stays 0.
